// File: rtl/spi_sclk_pkg.sv
// Shared state type and default widths for the SPI serial-clock generator.
package spi_sclk_pkg;

  localparam int unsigned DIV_W_DEF = 9;
  localparam int unsigned CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StRun,
    StHold
  } sclk_state_e;

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period tick generator: tick fires once every div+1 clk cycles while clear is low.
module spi_sclk_div
  import spi_sclk_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  // Counter restarts on every tick, so it never passes div and never wraps.
  assign tick = !clear && (r_cnt == div);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI SCLK generator: idle/setup/run/hold sequencer with sample/shift strobes.
// Define SPI_SCLK_GEN_CS_EN to add an active-low chip-select output cs_n.
module spi_sclk_gen
  import spi_sclk_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  input  logic             cpol,
  input  logic             cpha,
  output logic             sclk,
  output logic             sample_stb,
  output logic             shift_stb,
  output logic             busy,
  output logic             done
`ifdef SPI_SCLK_GEN_CS_EN
  ,
  output logic             cs_n
`endif
);

  sclk_state_e      r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_nbits;
  logic             r_cpol;
  logic             r_cpha;
  logic [CNT_W:0]   r_edge_cnt;
  logic             r_sclk;
  logic             r_sample_stb;
  logic             r_shift_stb;
  logic             r_busy;
  logic             r_done;

  logic             w_tick;
  logic             w_clear;
  logic [CNT_W:0]   w_edge_nxt;
  logic             w_lead;
  logic             w_last;

  // Divider is held at zero while idle, so SETUP always starts a fresh half-period.
  assign w_clear    = (r_state == StIdle) || abort;
  assign w_edge_nxt = r_edge_cnt + (CNT_W+1)'(1);
  assign w_lead     = w_edge_nxt[0];
  assign w_last     = (w_edge_nxt == {r_nbits, 1'b0});

  spi_sclk_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (w_clear),
    .div   (r_div),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= StIdle;
      r_div        <= '0;
      r_nbits      <= '0;
      r_cpol       <= 1'b0;
      r_cpha       <= 1'b0;
      r_edge_cnt   <= '0;
      r_sclk       <= 1'b0;
      r_sample_stb <= 1'b0;
      r_shift_stb  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_sample_stb <= 1'b0;
      r_shift_stb  <= 1'b0;
      r_done       <= 1'b0;
      if (abort && (r_state != StIdle)) begin
        r_state    <= StIdle;
        r_busy     <= 1'b0;
        r_sclk     <= r_cpol;
        r_edge_cnt <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_sclk <= cpol;
            if (start) begin
              if (nbits == '0) begin
                r_done <= 1'b1;
              end else begin
                r_div      <= div;
                r_nbits    <= nbits;
                r_cpol     <= cpol;
                r_cpha     <= cpha;
                r_edge_cnt <= '0;
                r_busy     <= 1'b1;
                r_state    <= StSetup;
              end
            end
          end
          StSetup, StRun: begin
            if (w_tick) begin
              r_sclk     <= ~r_sclk;
              r_edge_cnt <= w_edge_nxt;
              // Odd edge numbers are leading edges; the final trailing edge never shifts.
              if (w_lead) begin
                r_sample_stb <= !r_cpha;
                r_shift_stb  <= r_cpha;
              end else begin
                r_sample_stb <= r_cpha;
                r_shift_stb  <= !r_cpha && !w_last;
              end
              r_state <= w_last ? StHold : StRun;
            end
          end
          StHold: begin
            if (w_tick) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign sclk       = r_sclk;
  assign sample_stb = r_sample_stb;
  assign shift_stb  = r_shift_stb;
  assign busy       = r_busy;
  assign done       = r_done;

`ifdef SPI_SCLK_GEN_CS_EN
  assign cs_n = ~r_busy;
`endif

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: time-based reference model plus directed literal checks.
module tb_spi_sclk_gen;

  localparam int unsigned DIV_W = 9;
  localparam int unsigned CNT_W = 6;

  logic             clk   = 1'b0;
  logic             n_rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cpol  = 1'b0;
  logic             cpha  = 1'b0;
  logic [DIV_W-1:0] div   = '0;
  logic [CNT_W-1:0] nbits = '0;
  logic             sclk, sample_stb, shift_stb, busy, done;
`ifdef SPI_SCLK_GEN_CS_EN
  logic             cs_n;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  spi_sclk_gen #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .abort      (abort),
    .div        (div),
    .nbits      (nbits),
    .cpol       (cpol),
    .cpha       (cpha),
    .sclk       (sclk),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb),
    .busy       (busy),
    .done       (done)
`ifdef SPI_SCLK_GEN_CS_EN
    ,
    .cs_n       (cs_n)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks time since busy rose; outputs follow from arithmetic on it.
  bit   m_active = 1'b0;
  int   m_rel    = 0;
  int   m_hp     = 1;
  int   m_n      = 1;
  logic m_cpol   = 1'b0;
  logic m_cpha   = 1'b0;
  logic m_done   = 1'b0;
  logic m_idle_sclk = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_active    <= 1'b0;
      m_rel       <= 0;
      m_done      <= 1'b0;
      m_idle_sclk <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        m_idle_sclk <= cpol;
        if (start) begin
          if (nbits == '0) begin
            m_done <= 1'b1;
          end else begin
            m_active <= 1'b1;
            m_rel    <= 0;
            m_hp     <= int'(div) + 1;
            m_n      <= int'(nbits);
            m_cpol   <= cpol;
            m_cpha   <= cpha;
          end
        end
      end else if (abort) begin
        m_active    <= 1'b0;
        m_idle_sclk <= m_cpol;
      end else if (m_rel + 1 == (2 * m_n + 1) * m_hp) begin
        m_active    <= 1'b0;
        m_done      <= 1'b1;
        m_idle_sclk <= m_cpol;
      end else begin
        m_rel <= m_rel + 1;
      end
    end
  end

  int   x_k;
  logic x_sclk, x_busy, x_done, x_samp, x_shift;

  always_comb begin
    x_k     = 0;
    x_sclk  = m_idle_sclk;
    x_busy  = 1'b0;
    x_done  = m_done;
    x_samp  = 1'b0;
    x_shift = 1'b0;
    if (m_active) begin
      x_k    = m_rel / m_hp;
      x_sclk = m_cpol ^ x_k[0];
      x_busy = 1'b1;
      x_done = 1'b0;
      if (m_rel > 0 && (m_rel % m_hp) == 0) begin
        x_samp  = m_cpha ? !x_k[0] : x_k[0];
        x_shift = m_cpha ? x_k[0] : (!x_k[0] && x_k != 2 * m_n);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sclk", int'(sclk), int'(x_sclk));
      check("busy", int'(busy), int'(x_busy));
      check("done", int'(done), int'(x_done));
      check("sample_stb", int'(sample_stb), int'(x_samp));
      check("shift_stb", int'(shift_stb), int'(x_shift));
`ifdef SPI_SCLK_GEN_CS_EN
      check("cs_n", int'(cs_n), int'(!x_busy));
`endif
    end
  end

  task automatic run_xfer(input int d, input int n, input logic pol, input logic pha,
                          input bit disturb);
    int budget;
    bit seen;
    div   = DIV_W'(d);
    nbits = CNT_W'(n);
    cpol  = pol;
    cpha  = pha;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    budget = (2 * n + 1) * (d + 1) + 4;
    seen   = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (disturb && i == 3) begin
        start = 1'b1;
        div   = DIV_W'(d + 2);
        cpol  = ~pol;
        cpha  = ~pha;
        nbits = CNT_W'(n + 1);
      end
      if (disturb && i == 4) start = 1'b0;
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("done_within_budget", int'(seen), 1);
  endtask

  int   tab_d   [7] = '{0, 0, 2, 1, 4, 0, 511};
  int   tab_n   [7] = '{1, 1, 3, 5, 2, 63, 1};
  logic tab_pol [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic tab_pha [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [7:0] t_sclk, t_samp, t_shift, t_done, t_busy;
    int n_busy, n_samp, n_shift, n_bad, n_done;

    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_sclk", int'(sclk), 0);
    check("reset_done", int'(done), 0);
    @(posedge clk);
    #1;

    // div=0, nbits=2, mode 0: toggles at 2..5, samples at 2,4, shift at 3, done at 6.
    t_sclk = '0; t_samp = '0; t_shift = '0; t_done = '0; t_busy = '0;
    div = '0; nbits = CNT_W'(2); cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      t_sclk[c]  = sclk;
      t_samp[c]  = sample_stb;
      t_shift[c] = shift_stb;
      t_done[c]  = done;
      t_busy[c]  = busy;
    end
    @(posedge clk);
    #1;
    check("min_div_sclk_trace", int'(t_sclk), int'(8'b0001_0100));
    check("min_div_sample_trace", int'(t_samp), int'(8'b0001_0100));
    check("min_div_shift_trace", int'(t_shift), int'(8'b0000_1000));
    check("min_div_done_trace", int'(t_done), int'(8'b0100_0000));
    check("min_div_busy_trace", int'(t_busy), int'(8'b0011_1110));

    // div=3, nbits=8, cpol=1, cpha=1.
    cpol = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_sclk_cpol1", int'(sclk), 1);
    @(posedge clk);
    #1;
    div = DIV_W'(3); nbits = CNT_W'(8); cpha = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_busy = 0; n_samp = 0; n_shift = 0; n_bad = 0; n_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (done) n_done++;
      if (sample_stb) begin
        n_samp++;
        if (!sclk) n_bad++;
      end
      if (shift_stb) begin
        n_shift++;
        if (sclk) n_bad++;
      end
    end
    @(posedge clk);
    #1;
    check("mode3_busy_cycles", n_busy, 68);
    check("mode3_sample_count", n_samp, 8);
    check("mode3_shift_count", n_shift, 8);
    check("mode3_edge_polarity_errors", n_bad, 0);
    check("mode3_done_count", n_done, 1);

    // Abort during cycle 10 of a div=1, nbits=8 transfer.
    div = DIV_W'(1); nbits = CNT_W'(8); cpol = 1'b1; cpha = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_sclk", int'(sclk), 1);
    check("abort_done", int'(done), 0);
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_late_done", n_done, 0);
    @(posedge clk);
    #1;
    run_xfer(1, 8, 1'b1, 1'b0, 1'b0);

    // nbits=0: single done pulse, nothing else moves.
    cpol = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nbits = '0; div = DIV_W'(2); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0; n_busy = 0; n_bad = 0;
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (c == 1) check("zero_done_cycle1", int'(done), 1);
      if (busy) n_busy++;
      if (sclk) n_bad++;
    end
    @(posedge clk);
    #1;
    check("zero_done_count", n_done, 1);
    check("zero_busy_cycles", n_busy, 0);
    check("zero_sclk_moves", n_bad, 0);

    // Reset asserted mid-RUN.
    div = DIV_W'(1); nbits = CNT_W'(8); cpol = 1'b1; cpha = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrun_reset_outputs", int'({sclk, busy, done, sample_stb, shift_stb}), 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    run_xfer(2, 4, 1'b0, 1'b1, 1'b0);

    // Table of configurations, then disturbed runs.
    for (int i = 0; i < 7; i++) run_xfer(tab_d[i], tab_n[i], tab_pol[i], tab_pha[i], 1'b0);
    run_xfer(3, 4, 1'b0, 1'b1, 1'b1);
    run_xfer(0, 3, 1'b1, 1'b0, 1'b1);
    run_xfer(2, 6, 1'b1, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_sclk_gen.md
SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 Parameter DIV_W, default 9: width of runtime half-period divider input.
REQ-002 Parameter CNT_W, default 6: width of SCLK-cycle count input.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a transfer.
REQ-006 abort  input  1  synchronous transfer cancel.
REQ-007 div  input  DIV_W  half-period minus one, in clk cycles.
REQ-008 nbits  input  CNT_W  SCLK cycles per transfer.
REQ-009 cpol  input  1  SCLK idle level.
REQ-010 cpha  input  1  0 = sample leading edge, 1 = sample trailing edge.
REQ-011 sclk  output  1  registered serial clock.
REQ-012 sample_stb  output  1  one-cycle pulse on each sampling edge.
REQ-013 shift_stb  output  1  one-cycle pulse on each shifting edge.
REQ-014 busy  output  1  high while a transfer is in progress.
REQ-015 done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 States: IDLE, SETUP, RUN, HOLD; transitions occur only on half-period ticks, except start and abort.
REQ-017 Half-period = div+1 clk cycles; div=0 gives SCLK = clk/2; the divider counter restarts at zero on entry to SETUP.
REQ-018 start in IDLE with nbits != 0 latches div, nbits, cpol and cpha, then enters SETUP; busy rises the following cycle.
REQ-019 start in IDLE with nbits=0 produces no state change except a done pulse on the following cycle.
REQ-020 start while busy is ignored; input changes while busy are ignored.
REQ-021 SETUP lasts one half-period, with sclk=cpol, then enters RUN.
REQ-022 sclk toggles at every half-period tick from the end of SETUP, giving exactly 2*nbits toggles.
REQ-023 Timing: toggles occur at k*(div+1) cycles after busy rises, for k=1..2*nbits.
REQ-024 The final toggle enters HOLD; HOLD lasts one half-period.
REQ-025 On HOLD exit: state goes to IDLE, busy falls, and done pulses in the same cycle; busy is high for (2*nbits+1)*(div+1) cycles in total.
REQ-026 Strobes are coincident with the cycle in which sclk changes; edge 1 is the leading edge.
REQ-027 cpha=0: sample_stb on leading edges; shift_stb on trailing edges except the last.
REQ-028 cpha=1: shift_stb on leading edges; sample_stb on trailing edges.
REQ-029 Pulse count per transfer: nbits sample_stb pulses, and nbits (cpha=1) or nbits-1 (cpha=0) shift_stb pulses.
REQ-030 In IDLE, sclk follows the live cpol input with one-cycle latency.
REQ-031 abort in any non-IDLE state: next cycle enters IDLE, sclk=latched cpol, busy=0, no done pulse, no strobes.
REQ-032 abort wins over a simultaneous start or tick; abort in IDLE has no effect.
REQ-033 The half-period counter is DIV_W bits and never wraps; it compares against the latched div.
REQ-034 The edge counter is CNT_W+1 bits.

Reset
REQ-035 On n_rst low, immediately: state=IDLE, counters=0, sclk=0, sample_stb=0, shift_stb=0, busy=0, done=0.
REQ-036 After reset release, the first transfer requires a new start; there is no pending-request memory.

Configuration
REQ-037 Macro SPI_SCLK_GEN_CS_EN defined: adds output cs_n (1 bit, reset 1), which is 0 exactly while busy=1 and is cleared by abort in the same cycle as busy.
REQ-038 Macro SPI_SCLK_GEN_CS_EN undefined: no cs_n port or logic; all other behaviour is identical.

Structure
REQ-039 Package spi_sclk_pkg holds the state enumeration type and the default constants for DIV_W and CNT_W.
REQ-040 Sub-module spi_sclk_div, the half-period tick generator, has inputs clk, n_rst, clear and div, and output tick.

Verification
REQ-041 div=0, nbits=2, cpol=0, cpha=0, start at cycle 0:
- sclk toggles at cycles 2,3,4,5;
- sample_stb at cycles 2,4; shift_stb at cycle 3;
- done at cycle 6.
REQ-042 div=3, nbits=8, cpol=1, cpha=1:
- busy high 68 cycles;
- sclk idles 1;
- 8 shift_stb pulses on falling edges and 8 sample_stb pulses on rising edges.
REQ-043 abort at cycle 10 of a div=1, nbits=8 transfer: cycle 11 has busy=0, sclk=cpol and no done; a later start runs a full transfer.
REQ-044 nbits=0 with start: done pulses once, busy stays 0, sclk is unchanged.
REQ-045 n_rst asserted mid-RUN: outputs are at reset values immediately; start after release completes normally.
REQ-046 start pulsed while busy, and div/cpol changed mid-transfer: waveform is identical to an undisturbed run; with SPI_SCLK_GEN_CS_EN defined, cs_n equals ~busy throughout.
